// File: rtl/square.sv
// Sequential 16x16 squarer: shift-add over 16 iterations with a start/busy/done handshake.
// Defining SQUARE_EARLY_EXIT_EN stops the computation once the multiplier has run out of set bits.
module square (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [15:0] A,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  count_q, count_d;
    logic        armed_q, armed_d;
    logic [31:0] result_q, result_d;

    logic [31:0] acc_next;
    logic        early_exit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 16'd0;
            acc_q    <= 32'd0;
            count_q  <= 4'd0;
            armed_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            armed_q  <= armed_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        count_d    = count_q;
        armed_d    = armed_q;
        result_d   = result_q;
        acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        early_exit = 1'b0;
`ifdef SQUARE_EARLY_EXIT_EN
        // The first iteration always runs, so A=0 finishes in two edges like A=1.
        early_exit = (mplier_q == 16'd0) && (count_q != 4'd0);
`endif

        // A start needs init to have been seen low since the last start or reset.
        if (!init) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (init && armed_q) begin
                    state_d  = RUN;
                    mcand_d  = {16'd0, A};
                    mplier_d = A;
                    acc_d    = 32'd0;
                    count_d  = 4'd0;
                    armed_d  = 1'b0;
                end
            end
            RUN: begin
                if (early_exit) begin
                    state_d  = DONE;
                    result_d = acc_q;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = {mcand_q[30:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[15:1]};
                    count_d  = count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        state_d  = DONE;
                        result_d = acc_next;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q == RUN);

endmodule

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 SHALL: init  input  1  start request, level-sampled.
REQ-004 SHALL: A  input  16  unsigned operand, captured at start.
REQ-005 SHALL: result  output  32  unsigned A*A, registered.
REQ-006 SHALL: done  output  1  high for exactly one cycle when result is updated.
REQ-007 SHALL: busy  output  1  high while the FSM is in RUN.

Function
REQ-008 SHALL: FSM with three states: IDLE, RUN, DONE; done = (state==DONE); busy = (state==RUN).
REQ-009 SHALL: internal regs are mcand 32b, mplier 16b, acc 32b, count 4b, armed 1b.
REQ-010 SHALL: IDLE->RUN on an edge with init=1 and armed=1; that edge loads mcand={16'b0,A}, mplier=A, acc=0, count=0, and clears armed.
REQ-011 SHALL: armed is set on any edge where init=0, in every state.
REQ-012 SHALL: each RUN edge performs one shift-add iteration: if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; count+=1.
REQ-013 SHALL: the iteration with count==15 moves RUN->DONE and loads result with the final acc value, including that iteration's add.
REQ-014 SHALL: base latency is 16 edges: start at edge N, DONE entered and result valid at edge N+16, done high N+16..N+17.
REQ-015 SHALL: DONE->IDLE unconditionally on the next edge; result holds its value until the next DONE entry.
REQ-016 SHALL: init is ignored in RUN and DONE (no restart or abort).
REQ-017 SHALL: an init held high continuously across a completion does not retrigger; a new start requires init to be sampled low at least once first.
REQ-018 SHALL: all arithmetic is unsigned and modulo 2^32; no overflow is possible for 16-bit A (max 0xFFFE0001).
REQ-019 SHALL: A changes after the start edge do not affect the computation.

Reset
REQ-020 SHALL: rst=0 asynchronously forces state=IDLE, result=0, acc=0, mcand=0, mplier=0, count=0, armed=0, so done=0 and busy=0.
REQ-021 SHALL: reset mid-RUN abandons the operation; result stays 0 and no done pulse occurs.
REQ-022 SHALL: after rst is released, the first start requires init sampled low at least once (armed=0 at reset).

Configuration
REQ-023 SHALL: macro SQUARE_EARLY_EXIT_EN enables early termination of the computation.
REQ-024 SHALL (defined): a RUN edge with mplier==0 performs no iteration, moves RUN->DONE and loads result=acc.
REQ-025 SHALL (defined): early-exit latency is k+2 edges for an operand whose highest set bit is k (k<15), 2 edges for A=0, and 16 edges when A[15]=1.
REQ-026 SHALL (undefined): latency is always 16 edges per REQ-014, with results identical to the defined build.

Verification
REQ-027 SHALL: reset, init low one cycle, then init high 2 cycles with A=0x0190 -> result=0x00027100; done pulses once at start+16 (macro off) or start+10 (macro on); busy low afterwards.
REQ-028 SHALL: A=0xFFFF -> result=0xFFFE0001 at start+16 in both builds.
REQ-029 SHALL: A=0x0000 -> result=0x00000000 at start+16 (macro off) or start+2 (macro on).
REQ-030 SHALL: init held high for 40 cycles with A=0x0003 -> exactly one done pulse with result=0x00000009; a second pulse occurs only after init goes low then high.
REQ-031 SHALL: rst=0 asserted between clock edges 5 cycles after a start with A=0x1234 -> state IDLE, result=0, done=0 immediately; subsequent A=0x0010 -> result=0x00000100.
REQ-032 SHALL: A changed to 0xAAAA one cycle after a start with A=0x0007 -> result=0x00000031.
